// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring divider for DIV/DIVU/REM/REMU, resolving all M-extension corner cases.
module iter_divider #(
  parameter int XLEN = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int N = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q, quo_c, rem_c, a_abs, b_abs, fix_res;
  logic [XLEN:0] trial;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, is_rem, accept, sgn, div0, ovf, fast;
  always_comb begin
    accept = start && !kill && (state == IDLE || state == DONE);
    sgn = !op[0];
    div0 = divisor == '0;
    ovf = sgn && dividend == {1'b1, {(XLEN-1){1'b0}}} && &divisor;
    fast = div0 || ovf;
    // magnitude of the most negative value is exact when read back as unsigned
    a_abs = (sgn && dividend[XLEN-1]) ? -dividend : dividend;
    b_abs = (sgn && divisor[XLEN-1]) ? -divisor : divisor;
    fix_res = is_rem ? (neg_r ? -rem_q : rem_q) : (neg_q ? -quo_q : quo_q);
  end
  always_comb begin
    rem_c = rem_q;
    quo_c = quo_q;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial = {rem_c, quo_c[XLEN-1]};
      quo_c = {quo_c[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial = trial - {1'b0, dvs_q};
        quo_c[0] = 1'b1;
      end
      rem_c = trial[XLEN-1:0];
    end
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: state_nxt = accept ? (fast ? DONE : CALC) : IDLE;
      CALC:       state_nxt = kill ? IDLE : (cnt == CW'(1) ? FIX : CALC);
      default:    state_nxt = kill ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      is_rem <= 1'b0;
    end else begin
      busy <= state_nxt == CALC || state_nxt == FIX;
      done <= state_nxt == DONE;
      if (accept) begin
        quo_q <= a_abs;
        rem_q <= '0;
        dvs_q <= b_abs;
        cnt <= CW'(N);
        neg_q <= sgn && (dividend[XLEN-1] ^ divisor[XLEN-1]);
        neg_r <= sgn && dividend[XLEN-1];
        is_rem <= op[1];
        if (div0) result <= op[1] ? dividend : '1;
        else if (ovf) result <= op[1] ? '0 : dividend;
      end else if (state == CALC) begin
        quo_q <= quo_c;
        rem_q <= rem_c;
        cnt <= cnt - CW'(1);
      end else if (state == FIX && !kill) begin
        result <= fix_res;
      end
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: scoreboard bench for a radix-2 and a radix-16 divider instance.
module tb_iter_divider;
  logic clk = 1'b0;
  logic rst_n [2];
  logic st [2];
  logic kl [2];
  logic [1:0] opx [2];
  logic [31:0] ax [2];
  logic [31:0] bx [2];
  logic busy [2];
  logic done [2];
  logic [31:0] res [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  iter_divider #(.XLEN(32), .BITS_PER_CYCLE(1)) d1 (
    .clk(clk), .rst_n(rst_n[0]), .start(st[0]), .op(opx[0]), .dividend(ax[0]),
    .divisor(bx[0]), .kill(kl[0]), .busy(busy[0]), .done(done[0]), .result(res[0]));
  iter_divider #(.XLEN(32), .BITS_PER_CYCLE(4)) d4 (
    .clk(clk), .rst_n(rst_n[1]), .start(st[1]), .op(opx[1]), .dividend(ax[1]),
    .divisor(bx[1]), .kill(kl[1]), .busy(busy[1]), .done(done[1]), .result(res[1]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) return o[1] ? a : 32'hFFFFFFFF;
    if (!o[0]) return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    return o[1] ? a % b : a / b;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'd1;
      3: return 32'd0;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction
  always @(negedge clk) begin
    if (done[0]) begin
      if (q0.size() == 0) check("d1_unexpected_done", {31'b0, done[0]}, 32'd0);
      else check("d1_result", res[0], q0.pop_front());
    end
    if (done[1]) begin
      if (q1.size() == 0) check("d4_unexpected_done", {31'b0, done[1]}, 32'd0);
      else check("d4_result", res[1], q1.pop_front());
    end
  end
  task automatic run(input int u, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input bit poke);
    int lat, nb, want;
    bit fast;
    @(negedge clk);
    st[u] = 1'b1; opx[u] = o; ax[u] = a; bx[u] = b;
    if (u == 0) q0.push_back(exp); else q1.push_back(exp);
    @(posedge clk); #1 st[u] = 1'b0;
    lat = 0; nb = 0;
    while (!done[u] && lat < 100) begin
      nb += int'(busy[u]);
      if (poke && lat == 5) begin st[u] = 1'b1; ax[u] = 32'd77; end
      @(posedge clk); #1 st[u] = 1'b0;
      lat++;
    end
    fast = b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    want = fast ? 0 : (u == 0 ? 33 : 9);
    check("latency", 32'(lat), 32'(want));
    check("busy_cycles", 32'(nb), 32'(want));
  endtask
  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; st[u] = 1'b0; kl[u] = 1'b0; opx[u] = 2'b0; ax[u] = '0; bx[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_busy", {31'b0, busy[u]}, 32'd0);
      check("rst_done", {31'b0, done[u]}, 32'd0);
      check("rst_result", res[u], 32'd0);
    end
    @(negedge clk); rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    run(0, 2'b01, 32'd100, 32'd7, 32'd14, 0);
    run(0, 2'b11, 32'd100, 32'd7, 32'd2, 0);
    run(0, 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0);
    run(0, 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0);
    run(0, 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 0);
    run(0, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    run(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0);
    run(0, 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
    run(0, 2'b10, 32'h12345678, 32'd0, 32'h12345678, 0);
    // kill at CALC cycle 10 together with a competing start
    @(negedge clk); st[0] = 1'b1; opx[0] = 2'b01; ax[0] = 32'd50; bx[0] = 32'd5;
    @(posedge clk); #1 st[0] = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); kl[0] = 1'b1; st[0] = 1'b1; ax[0] = 32'd77; bx[0] = 32'd7;
    @(posedge clk); #1;
    check("kill_busy", {31'b0, busy[0]}, 32'd0);
    check("kill_done", {31'b0, done[0]}, 32'd0);
    kl[0] = 1'b0; st[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("kill_result_held", res[0], 32'h12345678);
    check("kill_start_dropped", {31'b0, busy[0]}, 32'd0);
    run(0, 2'b01, 32'd1000, 32'd10, 32'd100, 1);
    run(0, 2'b01, 32'd9, 32'd3, 32'd3, 0);
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < 1000; i++) begin
        logic [31:0] a, b;
        a = pick(); b = pick();
        run(1, 2'(o), a, b, ref_div(2'(o), a, b), 0);
      end
    // asynchronous reset in the middle of CALC
    @(negedge clk); st[1] = 1'b1; opx[1] = 2'b01; ax[1] = 32'hDEADBEEF; bx[1] = 32'd3;
    @(posedge clk); #1 st[1] = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n[1] = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy[1]}, 32'd0);
    check("arst_done", {31'b0, done[1]}, 32'd0);
    check("arst_result", res[1], 32'd0);
    @(negedge clk); rst_n[1] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("arst_no_done", {31'b0, done[1]}, 32'd0);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
